// File: rtl/neuron_mac_28.sv
// Single-neuron MAC sequencer: sweeps both BRAMs, accumulates Q8.8 products,
// adds bias, optional ReLU, saturates to one Q8.8 output (DONE 31 cycles after START).
module neuron_mac_28 #(
  parameter int N_TAPS = 28,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     start_i,
  input  logic                     relu_en_i,
  input  logic signed [DATA_W-1:0] bias_i,
  output logic        [ADDR_W-1:0] mem_addr_o,
  output logic                     mem_en_o,
  input  logic signed [DATA_W-1:0] w_data_i,
  input  logic signed [DATA_W-1:0] x_data_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic signed [DATA_W-1:0] y_o
);

  localparam int P_W = 2 * DATA_W;
  localparam int R_W = ACC_W - FRAC_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_TAPS - 1);
  localparam logic signed [R_W-1:0] Y_MAX = R_W'((1 <<< (DATA_W - 1)) - 1);
  localparam logic signed [R_W-1:0] Y_MIN = ~Y_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t                    state_q, state_d;
  logic        [ADDR_W-1:0]  addr_q, addr_d;
  logic signed [DATA_W-1:0]  bias_q;
  logic                      relu_q;
  logic signed [P_W-1:0]     p_q;
  logic                      p_vld_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic                      drain_q;
  logic signed [DATA_W-1:0]  y_q, y_d;
  logic                      accept;
  logic signed [R_W-1:0]     r_full;
  logic signed [R_W-1:0]     r_relu;

  assign accept = (state_q == IDLE) && start_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (addr_q == LAST_ADDR) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en_o = (state_q == RUN);
    busy_o   = (state_q == RUN) || (state_q == DRAIN);
    done_o   = (state_q == OUT);
  end

  always_comb begin
    addr_d = addr_q;
    if (accept)
      addr_d = '0;
    else if (state_q == RUN && addr_q != LAST_ADDR)
      addr_d = addr_q + ADDR_W'(1);
  end

  // Floor-shift the accumulator back to Q8.8, then bias, ReLU and saturate.
  always_comb begin
    r_full = $signed({acc_q[ACC_W-1], acc_q[ACC_W-1:FRAC_W]})
           + $signed({{(R_W - DATA_W){bias_q[DATA_W-1]}}, bias_q});
    r_relu = (relu_q && r_full < 0) ? '0 : r_full;
    if (r_relu > Y_MAX)      y_d = Y_MAX[DATA_W-1:0];
    else if (r_relu < Y_MIN) y_d = Y_MIN[DATA_W-1:0];
    else                     y_d = r_relu[DATA_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q  <= '0;
      bias_q  <= '0;
      relu_q  <= 1'b0;
      p_q     <= '0;
      p_vld_q <= 1'b0;
      acc_q   <= '0;
      drain_q <= 1'b0;
      y_q     <= '0;
    end else begin
      addr_q  <= addr_d;
      p_vld_q <= (state_q == RUN);
      drain_q <= (state_q == DRAIN);
      if (accept) begin
        bias_q <= bias_i;
        relu_q <= relu_en_i;
      end
      // Read data lands on the falling edge of the address cycle.
      if (state_q == RUN)
        p_q <= w_data_i * x_data_i;
      if (accept)
        acc_q <= '0;
      else if (p_vld_q)
        acc_q <= acc_q + $signed({{(ACC_W - P_W){p_q[P_W-1]}}, p_q});
      if (state_q == DRAIN && drain_q)
        y_q <= y_d;
    end
  end

  assign mem_addr_o = addr_q;
  assign y_o        = y_q;

endmodule

// File: tb/tb_neuron_mac_28.sv
// Scoreboard bench for neuron_mac_28: negedge BRAM model, directed sweeps,
// ignored-START and mid-sweep reset scenarios.
module tb_neuron_mac_28;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               relu_en = 1'b0;
  logic signed [15:0] bias = '0;
  logic [4:0]         mem_addr;
  logic               mem_en;
  logic signed [15:0] w_data = '0;
  logic signed [15:0] x_data = '0;
  logic               busy;
  logic               done;
  logic signed [15:0] y;

  neuron_mac_28 dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .relu_en_i(relu_en),
    .bias_i(bias), .mem_addr_o(mem_addr), .mem_en_o(mem_en),
    .w_data_i(w_data), .x_data_i(x_data), .busy_o(busy), .done_o(done), .y_o(y)
  );

  always #5 clk = ~clk;

  typedef struct {int y; int e0;} exp_t;
  exp_t sb[$];

  logic signed [15:0] w_mem [32];
  logic signed [15:0] x_mem [32];
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int en_cnt = 0;
  int addr_bad = 0;
  logic prev_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: DO updates on the falling edge of the cycle the address is shown.
  always @(negedge clk) begin
    if (mem_en) begin
      w_data <= w_mem[mem_addr];
      x_data <= x_mem[mem_addr];
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Monitor: address sequence tracking and scoreboard pop on DONE.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_en = 1'b0;
    end else begin
      if (mem_en) begin
        if (!prev_en) en_cnt = 0;
        if (int'(mem_addr) != en_cnt) addr_bad++;
        en_cnt++;
      end
      prev_en = mem_en;
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("y", int'(y), e.y);
          // DONE cycle follows E30: 31 cycles after the START edge.
          check("done_latency", cyc - e.e0, 30);
          check("mem_en_cycles", en_cnt, 28);
          check("addr_seq_errors", addr_bad, 0);
        end
      end
    end
  end

  task automatic load(input int wv, input int xv);
    for (int k = 0; k < 32; k++) begin
      w_mem[k] = 16'(wv);
      x_mem[k] = 16'(xv);
    end
  endtask

  task automatic start_sweep(input int b, input logic r, input int exp_y);
    @(negedge clk);
    start = 1'b1;
    bias = 16'(b);
    relu_en = r;
    @(posedge clk);
    #1;
    sb.push_back('{exp_y, cyc});
    start = 1'b0;
  endtask

  task automatic wait_done();
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk);
      if (done_cnt > d0) seen = 1;
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic run(input int wv, input int xv, input int b, input logic r, input int exp_y);
    load(wv, xv);
    start_sweep(b, r, exp_y);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int d0;
    bit seen;
    load(0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_y", int'(y), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_mem_en", int'(mem_en), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run(256, 256, 0, 1'b0, 7168);
    run(256, 256, -256, 1'b0, 6912);
    run(256, -256, 0, 1'b0, -7168);
    run(256, -256, 0, 1'b1, 0);
    run(32767, 32767, 0, 1'b0, 32767);
    run(32767, -32768, 0, 1'b0, -32768);
    // 28 * -1 raw = -28; floor shift gives -1, not 0.
    run(1, -1, 0, 1'b0, -1);

    // START at E5 and during DONE are ignored; the next cycle's START is taken.
    load(256, 256);
    start_sweep(0, 1'b0, 7168);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_e5_start", int'(busy), 1);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) check("done_timeout_ignore", 0, 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("busy_after_done_start", int'(busy), 0);
    @(posedge clk);
    #1;
    sb.push_back('{7168, cyc});
    start = 1'b0;
    check("busy_after_next_start", int'(busy), 1);
    wait_done();

    // Mid-sweep reset aborts with no DONE.
    load(256, 256);
    start_sweep(0, 1'b0, 7168);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check("abort_y", int'(y), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_mem_en", int'(mem_en), 0);
    check("abort_mem_addr", int'(mem_addr), 0);
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("no_done_after_abort", done_cnt - d0, 0);
    check("idle_after_abort", int'(busy), 0);

    // Ramp weights 0..27, X=1.0: sum k = 378.
    for (int k = 0; k < 32; k++) begin
      w_mem[k] = 16'(k);
      x_mem[k] = 16'sd256;
    end
    start_sweep(0, 1'b1, 378);
    wait_done();

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
